// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
//   fetch_state_t : fetch sequencer states
//   fetch_entry_t : one prefetch-queue slot {instr, pc}
//   DEFAULT_RESET_PC / DEFAULT_HALT_WORD : default parameter values for the top
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetch entries.
//   clk, rst_n : clock, synchronous active-low reset (clears contents)
//   push, push_data : enqueue request and entry
//   pop        : dequeue head (ignored when empty)
//   flush      : drop all entries; wins over push and pop
//   full, empty, head : status and current head entry
// Handshake: an entry is transferred out on any cycle where the consumer
// sees !empty and asserts pop; a push is accepted when not full or when a
// pop happens in the same cycle.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= push_data;
          else                 r_tail <= push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever remains.
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= push_data;
          end else begin
            r_head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign head  = r_head;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer for a combinational-read instruction ROM.
// Owns the byte PC, drives the ROM word address, buffers fetched words in a
// 2-entry prefetch queue and presents the head to decode.
//   clk, rst_n      : clock, synchronous active-low reset
//   en              : fetch enable
//   redirect_valid, redirect_pc : branch/jump redirect (bits [1:0] ignored)
//   imem_address, imem_read     : ROM word address / same-cycle data
//   instr_valid, instr_data, instr_pc, instr_ready : decode handshake
//   halted          : fetch stopped on the halt word
//   o_dbg_state     : current sequencer state, for observation
// Handshake: the head transfers to decode on any cycle where instr_valid
// and instr_ready are both high; instr_valid never depends on instr_ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          D         = 6,
  parameter int          W         = 32,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic [D-1:0] imem_address,
  input  logic [W-1:0] imem_read,
  output logic         instr_valid,
  output logic [W-1:0] instr_data,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready,
  output logic         halted,
  output logic [1:0]   o_dbg_state
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;

  // A redirect hides the head so decode never consumes a wrong-path word.
  assign instr_valid = !w_empty && !redirect_valid;
  assign w_pop       = instr_valid && instr_ready;
  assign w_push      = (r_state == FETCH) && en && !redirect_valid &&
                       (!w_full || w_pop);

  assign w_push_entry = '{instr: imem_read, pc: r_pc};
  assign imem_address = r_pc[D+1:2];

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (!en)                                 w_state_next = IDLE;
          else if (w_push && imem_read == HALT_WORD) w_state_next = HALTED;
        end
        IDLE:    if (en) w_state_next = FETCH;
        HALTED:  w_state_next = HALTED;
        default: w_state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) r_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (w_push)    r_pc <= r_pc + 32'd4;
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign instr_data  = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign halted      = (r_state == HALTED);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int          D    = 6;
  localparam int          W    = 32;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         en;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [D-1:0] imem_address;
  logic [W-1:0] imem_read;
  logic         instr_valid;
  logic [W-1:0] instr_data;
  logic [31:0]  instr_pc;
  logic         instr_ready;
  logic         halted;
  logic [1:0]   dbg_state;

  logic [31:0] rom [0:63];
  assign imem_read = rom[imem_address];

  instr_fetch_unit #(.D(D), .W(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_address   (imem_address),
    .imem_read      (imem_read),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .halted         (halted),
    .o_dbg_state    (dbg_state)
  );

  // reference model: expected queue of {pc, instr}, fetch pointer, run mode
  logic [63:0]  exp_q[$];
  logic [31:0]  m_pc;
  bit           m_halted;
  bit           m_idle;
  bit           e_valid;
  logic [31:0]  e_pc;
  logic [31:0]  e_data;
  logic [D-1:0] e_addr;
  bit           e_halted;

  int total = 0;
  int bad   = 0;

  function automatic void model_outputs();
    e_valid  = (exp_q.size() > 0) && !redirect_valid;
    e_pc     = (exp_q.size() > 0) ? exp_q[0][63:32] : 32'h0;
    e_data   = (exp_q.size() > 0) ? exp_q[0][31:0]  : 32'h0;
    e_addr   = m_pc[D+1:2];
    e_halted = m_halted;
  endfunction

  // driver: advance one clock, updating the model with the inputs applied
  task automatic step();
    bit pop;
    logic [31:0] word;
    model_outputs();
    pop = e_valid && instr_ready;
    if (!rst_n) begin
      exp_q.delete(); m_pc = 32'h0; m_halted = 0; m_idle = 0;
    end else if (redirect_valid) begin
      exp_q.delete(); m_pc = {redirect_pc[31:2], 2'b00}; m_halted = 0; m_idle = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (!m_halted && !m_idle) begin
        if (!en) m_idle = 1;
        else if (exp_q.size() < 2) begin
          word = rom[m_pc[D+1:2]];
          exp_q.push_back({m_pc, word});
          if (word == HALT) m_halted = 1;
          m_pc = m_pc + 32'd4;
        end
      end else if (m_idle && en) begin
        m_idle = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 64; i++) rom[i] = ($urandom() & 32'h0FFF_FF00) | i;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    #1;
    total++;
    if (instr_valid !== 1'b0 || halted !== 1'b0 || instr_data !== 32'h0 ||
        instr_pc !== 32'h0 || imem_address !== 6'd0) begin
      bad++;
      $display("FAIL reset_values got v=%b h=%b d=%h pc=%h a=%0d exp v=0 h=0 d=0 pc=0 a=0",
               instr_valid, halted, instr_data, instr_pc, imem_address);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL reset_first_cycle_valid got=%b exp=0", instr_valid);
    end
    step();
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== rom[0]) begin
      bad++;
      $display("FAIL reset_first_valid got v=%b pc=%h d=%h exp v=1 pc=0 d=%h",
               instr_valid, instr_pc, instr_data, rom[0]);
    end
    step();
  endtask

  task automatic test_sequential();
    do_reset();
    en = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      total++;
      if (instr_valid !== (k >= 1)) begin
        bad++; $display("FAIL seq_valid cyc=%0d got=%b exp=%b", k, instr_valid, k >= 1);
      end else if (k >= 1) begin
        total++;
        if (instr_pc !== 32'(4 * (k - 1)) || instr_data !== rom[k-1]) begin
          bad++;
          $display("FAIL seq_head cyc=%0d got pc=%h d=%h exp pc=%h d=%h",
                   k, instr_pc, instr_data, 32'(4 * (k - 1)), rom[k-1]);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; instr_ready = 1'b0;
    repeat (5) step();
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_address !== 6'd2) begin
      bad++;
      $display("FAIL bp_stall got v=%b pc=%h a=%0d exp v=1 pc=0 a=2",
               instr_valid, instr_pc, imem_address);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k)) begin
        bad++;
        $display("FAIL bp_drain k=%0d got v=%b pc=%h exp v=1 pc=%h",
                 k, instr_valid, instr_pc, 32'(4 * k));
      end
      step();
    end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    en = 1'b1; instr_ready = 1'b1; found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      #1;
      if (instr_valid === 1'b1 && instr_pc === 32'h8) found = 1;
      else step();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL redir_wait got=no head at pc 8 exp=head at pc 8");
    end
    redirect_valid = 1'b1; redirect_pc = 32'h2B;
    #1;
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL redir_valid_low got=%b exp=0", instr_valid);
    end
    step();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || imem_address !== 6'd10) begin
      bad++;
      $display("FAIL redir_flush got v=%b a=%0d exp v=0 a=10", instr_valid, imem_address);
    end
    step();
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h28 || instr_data !== rom[10]) begin
      bad++;
      $display("FAIL redir_target got v=%b pc=%h d=%h exp v=1 pc=28 d=%h",
               instr_valid, instr_pc, instr_data, rom[10]);
    end
    step();
  endtask

  task automatic test_halt();
    logic [31:0] got_q[$];
    rom[5] = HALT;
    do_reset();
    en = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (instr_valid === 1'b1) got_q.push_back(instr_pc);
      total++;
      if (halted !== (k >= 6)) begin
        bad++; $display("FAIL halt_flag cyc=%0d got=%b exp=%b", k, halted, k >= 6);
      end
      step();
    end
    total++;
    if (got_q.size() != 6) begin
      bad++; $display("FAIL halt_count got=%0d exp=6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (got_q[i] !== 32'(4 * i)) begin
          bad++; $display("FAIL halt_order i=%0d got=%h exp=%h", i, got_q[i], 32'(4 * i));
        end
      end
    end
    #1;
    total++;
    if (imem_address !== 6'd6) begin
      bad++; $display("FAIL halt_addr_held got=%0d exp=6", imem_address);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (halted !== 1'b0) begin
      bad++; $display("FAIL halt_release got=%b exp=0", halted);
    end
    step();
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL halt_resume got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc);
    end
    step();
    rom[5] = 32'h0000_0505;
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFC;
    step();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (imem_address !== 6'd63) begin
      bad++; $display("FAIL wrap_addr_top got=%0d exp=63", imem_address);
    end
    step();
    #1;
    total++;
    if (imem_address !== 6'd0 || instr_pc !== 32'hFC || instr_data !== rom[63]) begin
      bad++;
      $display("FAIL wrap_addr_zero got a=%0d pc=%h d=%h exp a=0 pc=fc d=%h",
               imem_address, instr_pc, instr_data, rom[63]);
    end
    step();
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_data !== rom[0]) begin
      bad++;
      $display("FAIL wrap_head got v=%b pc=%h d=%h exp v=1 pc=100 d=%h",
               instr_valid, instr_pc, instr_data, rom[0]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; instr_ready = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; instr_ready = 1'b1;
    #1;
    total++;
    if (instr_valid !== 1'b0 || halted !== 1'b0 || instr_data !== 32'h0 ||
        instr_pc !== 32'h0 || imem_address !== 6'd0) begin
      bad++;
      $display("FAIL midreset_values got v=%b h=%b d=%h pc=%h a=%0d exp v=0 h=0 d=0 pc=0 a=0",
               instr_valid, halted, instr_data, instr_pc, imem_address);
    end
    step();
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL midreset_first got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++)
      if ($urandom_range(0, 19) == 0) rom[i] = HALT;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      en             = ($urandom_range(0, 9) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom();
      rst_n          = ($urandom_range(0, 49) != 0);
      #1;
      model_outputs();
      total++;
      if (instr_valid !== e_valid || halted !== e_halted || imem_address !== e_addr) begin
        bad++;
        $display("FAIL rand_ctrl cyc=%0d got v=%b h=%b a=%0d exp v=%b h=%b a=%0d",
                 k, instr_valid, halted, imem_address, e_valid, e_halted, e_addr);
      end
      if (e_valid) begin
        total++;
        if (instr_pc !== e_pc || instr_data !== e_data) begin
          bad++;
          $display("FAIL rand_head cyc=%0d got pc=%h d=%h exp pc=%h d=%h",
                   k, instr_pc, instr_data, e_pc, e_data);
        end
      end
      step();
    end
    rst_n = 1'b1; redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    m_pc = 32'h0; m_halted = 0; m_idle = 0;
    fill_rom();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
